// File: rtl/decode_pkg.sv
// Shared constants and types for the decode front end: format mask weights,
// execution unit IDs and field widths.
package decode_pkg;

  localparam int ADDR_W   = 64;
  localparam int INSTR_W  = 32;
  localparam int PID_W    = 20;
  localparam int TID_W    = 16;
  localparam int ID_W     = 64;
  localparam int OPCODE_W = 6;
  localparam int FMT_W    = 26;

  // Declared [0:25] to match the big-endian bit numbering used across the ISA.
  typedef logic [0:FMT_W-1] format_mask_t;

  localparam format_mask_t FMT_A   = 26'd1 << 0;
  localparam format_mask_t FMT_B   = 26'd1 << 1;
  localparam format_mask_t FMT_D   = 26'd1 << 2;
  localparam format_mask_t FMT_DQ  = 26'd1 << 3;
  localparam format_mask_t FMT_DS  = 26'd1 << 4;
  localparam format_mask_t FMT_DX  = 26'd1 << 5;
  localparam format_mask_t FMT_I   = 26'd1 << 6;
  localparam format_mask_t FMT_M   = 26'd1 << 7;
  localparam format_mask_t FMT_MD  = 26'd1 << 8;
  localparam format_mask_t FMT_MDS = 26'd1 << 9;
  localparam format_mask_t FMT_SC  = 26'd1 << 10;
  localparam format_mask_t FMT_VA  = 26'd1 << 11;
  localparam format_mask_t FMT_VC  = 26'd1 << 12;
  localparam format_mask_t FMT_VX  = 26'd1 << 13;
  localparam format_mask_t FMT_X   = 26'd1 << 14;
  localparam format_mask_t FMT_XFL = 26'd1 << 15;
  localparam format_mask_t FMT_XFX = 26'd1 << 16;
  localparam format_mask_t FMT_XL  = 26'd1 << 17;
  localparam format_mask_t FMT_XO  = 26'd1 << 18;
  localparam format_mask_t FMT_XS  = 26'd1 << 19;
  localparam format_mask_t FMT_XX2 = 26'd1 << 20;
  localparam format_mask_t FMT_XX3 = 26'd1 << 21;
  localparam format_mask_t FMT_XX4 = 26'd1 << 22;
  localparam format_mask_t FMT_Z22 = 26'd1 << 23;
  localparam format_mask_t FMT_Z23 = 26'd1 << 24;
  localparam format_mask_t FMT_EVX = 26'd1 << 25;

  typedef enum logic [2:0] {
    UNIT_FX     = 3'd0,
    UNIT_FP     = 3'd1,
    UNIT_VX     = 3'd2,
    UNIT_CR     = 3'd3,
    UNIT_LS     = 3'd4,
    UNIT_BRANCH = 3'd6
  } unit_e;

endpackage

// File: rtl/decode_format_stage_if.sv
// Fetch-side handshake and decoded bundle of decode_format_stage.
// illegal_o exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_format_stage_if #(
  parameter int addressWidth            = decode_pkg::ADDR_W,
  parameter int instructionWidth        = decode_pkg::INSTR_W,
  parameter int PidSize                 = decode_pkg::PID_W,
  parameter int TidSize                 = decode_pkg::TID_W,
  parameter int instructionCounterWidth = decode_pkg::ID_W,
  parameter int opcodeSize              = decode_pkg::OPCODE_W
);
  // Handshake: an instruction transfers on a rising edge where fetchValid_i and
  // fetchReady_o are both high and flush_i is low; fetchReady_o is a register
  // output. A bundle is offered while enable_o is high and is taken downstream
  // on every edge where stall_i is low; while stall_i is high it holds still.
  logic                                fetchValid_i;
  logic                                fetchReady_o;
  logic [0:instructionWidth-1]         instruction_i;
  logic [addressWidth-1:0]             instructionAddress_i;
  logic                                is64Bit_i;
  logic [PidSize-1:0]                  instructionPid_i;
  logic [TidSize-1:0]                  instructionTid_i;
  logic                                flush_i;
  logic                                stall_i;

  logic                                enable_o;
  decode_pkg::format_mask_t            instFormat_o;
  logic [0:opcodeSize-1]               instructionOpcode_o;
  logic [0:instructionWidth-1]         instruction_o;
  logic [addressWidth-1:0]             instructionAddress_o;
  logic                                is64Bit_o;
  logic [PidSize-1:0]                  instPid_o;
  logic [TidSize-1:0]                  instTid_o;
  logic [instructionCounterWidth-1:0]  instMajId_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                                illegal_o;
`endif

  // Loads the major ID counter; used to reach the wrap point quickly.
  logic                                id_preload_valid;
  logic [instructionCounterWidth-1:0]  id_preload_value;

  modport master (
    output fetchValid_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, flush_i, stall_i,
           id_preload_valid, id_preload_value,
    input  fetchReady_o, enable_o, instFormat_o, instructionOpcode_o,
           instruction_o, instructionAddress_o, is64Bit_o, instPid_o,
           instTid_o, instMajId_o
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input illegal_o
`endif
  );

  modport slave (
    input  fetchValid_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, flush_i, stall_i,
           id_preload_valid, id_preload_value,
    output fetchReady_o, enable_o, instFormat_o, instructionOpcode_o,
           instruction_o, instructionAddress_o, is64Bit_o, instPid_o,
           instTid_o, instMajId_o
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output illegal_o
`endif
  );

endinterface

// File: rtl/decode_format_lut.sv
// Primary opcode to instruction-format mask. Several bits may be set; the
// format decoders disambiguate using the extended opcode.
module decode_format_lut
  import decode_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output format_mask_t        mask
);

  always_comb begin
    mask = '0;
    case (opcode) inside
      6'd16:                                   mask = FMT_B;
      6'd18:                                   mask = FMT_I;
      6'd17:                                   mask = FMT_SC;
      [6'd7:6'd15], [6'd24:6'd29], [6'd32:6'd55]: mask = FMT_D;
      6'd20, 6'd21, 6'd23:                     mask = FMT_M;
      6'd30:                                   mask = FMT_MD | FMT_MDS;
      6'd31:                                   mask = FMT_X | FMT_XO | FMT_XFX | FMT_XS;
      6'd19:                                   mask = FMT_XL | FMT_XFX;
      6'd58, 6'd62:                            mask = FMT_DS;
      6'd56, 6'd61:                            mask = FMT_DQ | FMT_DS;
      6'd4:                                    mask = FMT_VA | FMT_VC | FMT_VX;
      6'd59, 6'd63:                            mask = FMT_A | FMT_X | FMT_XFL | FMT_Z22 | FMT_Z23;
      6'd60:                                   mask = FMT_XX2 | FMT_XX3 | FMT_XX4;
      default:                                 mask = '0;
    endcase
  end

endmodule

// File: rtl/decode_format_stage.sv
// First decode stage: classifies the primary opcode, assigns the major ID and
// presents a registered bundle behind a 2-entry skid. DECODE_ILLEGAL_TRAP_EN
// forwards unknown opcodes flagged on illegal_o instead of dropping them.
module decode_format_stage
  import decode_pkg::*;
#(
  parameter int addressWidth            = ADDR_W,
  parameter int instructionWidth        = INSTR_W,
  parameter int PidSize                 = PID_W,
  parameter int TidSize                 = TID_W,
  parameter int instructionCounterWidth = ID_W,
  parameter int opcodeSize              = OPCODE_W
) (
  input logic                  clock_i,
  input logic                  reset_i,
  decode_format_stage_if.slave bus
);

  typedef struct packed {
    logic [0:instructionWidth-1]        instr;
    logic [addressWidth-1:0]            addr;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] id;
    format_mask_t                       fmt;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                               illegal;
`endif
  } bundle_t;

  format_mask_t                       in_mask;
  bundle_t                            in_b;
  bundle_t                            out_q, out_d, skid_q, skid_d;
  logic                               out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic                               fetch_ready_q;
  logic [instructionCounterWidth-1:0] id_cnt_q;
  logic                               accept, keep;

  decode_format_lut u_lut (
    .opcode (bus.instruction_i[0:opcodeSize-1]),
    .mask   (in_mask)
  );

  assign accept = bus.fetchValid_i && fetch_ready_q && !bus.flush_i;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign keep = accept;
`else
  // Unknown opcodes are consumed from fetch but never reach the output.
  assign keep = accept && (in_mask != '0);
`endif

  always_comb begin
    in_b       = '0;
    in_b.instr = bus.instruction_i;
    in_b.addr  = bus.instructionAddress_i;
    in_b.is64  = bus.is64Bit_i;
    in_b.pid   = bus.instructionPid_i;
    in_b.tid   = bus.instructionTid_i;
    in_b.id    = id_cnt_q;
    in_b.fmt   = in_mask;
`ifdef DECODE_ILLEGAL_TRAP_EN
    in_b.illegal = (in_mask == '0);
`endif
  end

  // Skid drains ahead of new input; a held skid entry implies fetchReady_o
  // was low, so the skid and a new input never compete for the skid slot.
  always_comb begin
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    out_d    = out_q;
    skid_d   = skid_q;
    if (bus.flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q && !bus.stall_i) begin
      out_d    = skid_q;
      out_v_d  = 1'b1;
      skid_v_d = keep;
      if (keep) skid_d = in_b;
    end else if (!out_v_q || !bus.stall_i) begin
      out_v_d = keep;
      if (keep) out_d = in_b;
    end else if (keep) begin
      skid_v_d = 1'b1;
      skid_d   = in_b;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_q         <= '0;
      skid_q        <= '0;
      out_v_q       <= 1'b0;
      skid_v_q      <= 1'b0;
      fetch_ready_q <= 1'b1;
      id_cnt_q      <= '0;
    end else begin
      out_q         <= out_d;
      skid_q        <= skid_d;
      out_v_q       <= out_v_d;
      skid_v_q      <= skid_v_d;
      fetch_ready_q <= !skid_v_d;
      if (bus.id_preload_valid) id_cnt_q <= bus.id_preload_value;
      else if (keep)            id_cnt_q <= id_cnt_q + 1'b1;
    end
  end

  assign bus.fetchReady_o         = fetch_ready_q;
  assign bus.enable_o             = out_v_q;
  assign bus.instFormat_o         = out_q.fmt;
  assign bus.instructionOpcode_o  = out_q.instr[0:opcodeSize-1];
  assign bus.instruction_o        = out_q.instr;
  assign bus.instructionAddress_o = out_q.addr;
  assign bus.is64Bit_o            = out_q.is64;
  assign bus.instPid_o            = out_q.pid;
  assign bus.instTid_o            = out_q.tid;
  assign bus.instMajId_o          = out_q.id;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.illegal_o            = out_q.illegal;
`endif

endmodule

// File: tb/tb_decode_format_stage.sv
// Bench for decode_format_stage: opcode table sweep, random stream with stall,
// and hand sequences for stall, flush, ID wrap, reset and illegal opcodes.
module tb_decode_format_stage;
  import decode_pkg::*;

  localparam int W = 1 + 6 + 26 + 32 + 64 + 1 + 20 + 16 + 64;

  typedef struct {
    logic [5:0]  op;
    logic [25:0] mask;
  } vec_t;

  logic clk;
  logic rst;
  decode_format_stage_if bus ();

  decode_format_stage dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [63:0] exp_id;
  vec_t        vecs[$];

  function automatic logic [W-1:0] actual_bundle();
    logic ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
    ill = bus.illegal_o;
`else
    ill = 1'b0;
`endif
    return {ill, bus.instructionOpcode_o, bus.instFormat_o, bus.instruction_o,
            bus.instructionAddress_o, bus.is64Bit_o, bus.instPid_o,
            bus.instTid_o, bus.instMajId_o};
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom()), 32'($urandom())};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // driver + scoreboard: one call per clock, acting at the falling edge
  task automatic step(input logic v, input logic [5:0] op, input logic [25:0] mask,
                      input logic [63:0] addr, input logic st, input logic fl);
    logic [31:0] instr;
    logic [19:0] pid;
    logic [15:0] tid;
    logic        is64;
    logic        keep;
    logic        ill;
    instr = {op, 26'($urandom())};
    pid   = 20'($urandom());
    tid   = 16'($urandom());
    is64  = 1'($urandom());
    @(negedge clk);
    bus.fetchValid_i         = v;
    bus.instruction_i        = instr;
    bus.instructionAddress_i = addr;
    bus.is64Bit_i            = is64;
    bus.instructionPid_i     = pid;
    bus.instructionTid_i     = tid;
    bus.stall_i              = st;
    bus.flush_i              = fl;
    if (bus.enable_o && !st && !fl) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bundle got=%h want=none", actual_bundle());
      end else begin
        check_vec("bundle", actual_bundle(), exp_q.pop_front());
      end
    end
    if (fl) begin
      exp_q.delete();
    end else if (v && bus.fetchReady_o) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      keep = 1'b1;
      ill  = (mask == 26'd0);
`else
      keep = (mask != 26'd0);
      ill  = 1'b0;
`endif
      if (keep) begin
        exp_q.push_back({ill, op, mask, instr, addr, is64, pid, tid, exp_id});
        exp_id = exp_id + 64'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 26'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                  = 1'b1;
    bus.fetchValid_i     = 1'b0;
    bus.stall_i          = 1'b0;
    bus.flush_i          = 1'b0;
    bus.id_preload_valid = 1'b0;
    @(negedge clk);
    check_bit("reset_enable", bus.enable_o, 1'b0);
    check_bit("reset_ready", bus.fetchReady_o, 1'b1);
    check_vec("reset_bundle", actual_bundle(), '0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_id = 64'd0;
  endtask

  initial begin
    rst                      = 1'b1;
    exp_id                   = 64'd0;
    bus.fetchValid_i         = 1'b0;
    bus.instruction_i        = '0;
    bus.instructionAddress_i = '0;
    bus.is64Bit_i            = 1'b0;
    bus.instructionPid_i     = '0;
    bus.instructionTid_i     = '0;
    bus.flush_i              = 1'b0;
    bus.stall_i              = 1'b0;
    bus.id_preload_valid     = 1'b0;
    bus.id_preload_value     = '0;

    vecs.push_back('{6'd16, 26'h1 << 1});
    vecs.push_back('{6'd18, 26'h1 << 6});
    vecs.push_back('{6'd17, 26'h1 << 10});
    vecs.push_back('{6'd7,  26'h1 << 2});
    vecs.push_back('{6'd15, 26'h1 << 2});
    vecs.push_back('{6'd24, 26'h1 << 2});
    vecs.push_back('{6'd29, 26'h1 << 2});
    vecs.push_back('{6'd32, 26'h1 << 2});
    vecs.push_back('{6'd55, 26'h1 << 2});
    vecs.push_back('{6'd20, 26'h1 << 7});
    vecs.push_back('{6'd21, 26'h1 << 7});
    vecs.push_back('{6'd23, 26'h1 << 7});
    vecs.push_back('{6'd30, 26'h0000300});
    vecs.push_back('{6'd31, 26'h00D4000});
    vecs.push_back('{6'd19, 26'h0030000});
    vecs.push_back('{6'd58, 26'h1 << 4});
    vecs.push_back('{6'd62, 26'h1 << 4});
    vecs.push_back('{6'd56, 26'h0000018});
    vecs.push_back('{6'd61, 26'h0000018});
    vecs.push_back('{6'd4,  26'h0003800});
    vecs.push_back('{6'd59, 26'h180C001});
    vecs.push_back('{6'd63, 26'h180C001});
    vecs.push_back('{6'd60, 26'h0700000});
    vecs.push_back('{6'd0,  26'h0});
    vecs.push_back('{6'd1,  26'h0});
    vecs.push_back('{6'd6,  26'h0});
    vecs.push_back('{6'd22, 26'h0});
    vecs.push_back('{6'd57, 26'h0});

    do_reset();

    // first instruction: opcode 16 at 0x100, one-cycle latency, ID 0
    step(1'b1, 6'd16, 26'h1 << 1, 64'h100, 1'b0, 1'b0);
    step(1'b0, 6'd0, 26'd0, 64'd0, 1'b0, 1'b0);
    check_bit("first_ready", bus.fetchReady_o, 1'b1);
    idle(2);

    // back-to-back 18, 14, 31 from a fresh reset: IDs 0, 1, 2
    do_reset();
    step(1'b1, 6'd18, 26'h1 << 6, rnd64(), 1'b0, 1'b0);
    step(1'b1, 6'd14, 26'h1 << 2, rnd64(), 1'b0, 1'b0);
    check_bit("b2b_enable", bus.enable_o, 1'b1);
    step(1'b1, 6'd31, 26'h00D4000, rnd64(), 1'b0, 1'b0);
    idle(3);

    // opcode table sweep, one per cycle
    for (int i = 0; i < vecs.size(); i++)
      step(1'b1, vecs[i].op, vecs[i].mask, rnd64(), 1'b0, 1'b0);
    idle(3);

    // stall for 3 cycles while fetch streams
    step(1'b1, 6'd18, 26'h1 << 6, rnd64(), 1'b0, 1'b0);
    step(1'b1, 6'd16, 26'h1 << 1, rnd64(), 1'b1, 1'b0);
    check_bit("stall_ready_before", bus.fetchReady_o, 1'b1);
    step(1'b1, 6'd7, 26'h1 << 2, rnd64(), 1'b1, 1'b0);
    check_bit("stall_ready_low", bus.fetchReady_o, 1'b0);
    step(1'b1, 6'd7, 26'h1 << 2, rnd64(), 1'b1, 1'b0);
    step(1'b1, 6'd7, 26'h1 << 2, rnd64(), 1'b0, 1'b0);
    step(1'b1, 6'd7, 26'h1 << 2, rnd64(), 1'b0, 1'b0);
    check_bit("stall_ready_back", bus.fetchReady_o, 1'b1);
    idle(3);

    // illegal opcode 1
    step(1'b1, 6'd1, 26'd0, rnd64(), 1'b0, 1'b0);
    step(1'b0, 6'd0, 26'd0, 64'd0, 1'b0, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check_bit("illegal_enable", bus.enable_o, 1'b1);
`else
    check_bit("illegal_enable", bus.enable_o, 1'b0);
`endif
    step(1'b1, 6'd18, 26'h1 << 6, rnd64(), 1'b0, 1'b0);
    idle(2);

    // flush with both entries full and a valid input
    step(1'b1, 6'd16, 26'h1 << 1, rnd64(), 1'b1, 1'b0);
    step(1'b1, 6'd17, 26'h1 << 10, rnd64(), 1'b1, 1'b0);
    step(1'b1, 6'd18, 26'h1 << 6, rnd64(), 1'b1, 1'b1);
    step(1'b0, 6'd0, 26'd0, 64'd0, 1'b0, 1'b0);
    check_bit("flush_enable", bus.enable_o, 1'b0);
    check_bit("flush_ready", bus.fetchReady_o, 1'b1);
    // flush while ready: the input is dropped and takes no ID
    step(1'b1, 6'd19, 26'h0030000, rnd64(), 1'b0, 1'b1);
    step(1'b1, 6'd20, 26'h1 << 7, rnd64(), 1'b0, 1'b0);
    idle(3);

    // ID wrap from all-ones
    @(negedge clk);
    bus.fetchValid_i     = 1'b0;
    bus.id_preload_valid = 1'b1;
    bus.id_preload_value = '1;
    exp_id               = '1;
    @(negedge clk);
    bus.id_preload_valid = 1'b0;
    step(1'b1, 6'd16, 26'h1 << 1, rnd64(), 1'b0, 1'b0);
    step(1'b1, 6'd18, 26'h1 << 6, rnd64(), 1'b0, 1'b0);
    idle(3);

    // random stream with random stall
    for (int i = 0; i < 300; i++) begin
      int idx;
      idx = $urandom_range(0, vecs.size() - 1);
      step($urandom_range(0, 3) != 0, vecs[idx].op, vecs[idx].mask, rnd64(),
           $urandom_range(0, 3) == 0, 1'b0);
    end
    idle(4);

    // reset mid-stream with both entries occupied
    step(1'b1, 6'd16, 26'h1 << 1, rnd64(), 1'b1, 1'b0);
    step(1'b1, 6'd17, 26'h1 << 10, rnd64(), 1'b1, 1'b0);
    do_reset();
    step(1'b1, 6'd30, 26'h0000300, rnd64(), 1'b0, 1'b0);
    idle(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_empty got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_format_stage.md
# decode_format_stage

First decode stage, between instruction fetch and the format-specific decoders (A, B, D, I, X, ...). It accepts one fetched 32-bit instruction per cycle and classifies its primary opcode into a one-hot-per-format mask. It assigns the 64-bit major instruction ID and presents a registered bundle that every format decoder samples; each decoder claims the instruction when its format bit is set. A 2-entry skid buffer absorbs downstream stall so the fetch handshake stays fully registered.

## Interface
Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, fixed instruction size
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- opcodeSize, 6, primary opcode width

Ports (clock and reset first):
- clock_i  in  1  clock; one clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- fetchValid_i  in  1  fetch presents an instruction
- fetchReady_o  out  1  stage can accept; registered
- instruction_i  in  32  instruction word, bit 0 = MSB
- instructionAddress_i  in  64  instruction address
- is64Bit_i  in  1  64-bit mode
- instructionPid_i  in  20  process ID
- instructionTid_i  in  16  thread ID
- flush_i  in  1  discard all held and incoming instructions
- stall_i  in  1  downstream cannot take a new bundle
- enable_o  out  1  bundle valid
- instFormat_o  out  26  format mask [0:25]
- instructionOpcode_o  out  6  instruction_i[0:5]
- instruction_o  out  32  full instruction word
- instructionAddress_o  out  64
- is64Bit_o  out  1
- instPid_o  out  20
- instTid_o  out  16
- instMajId_o  out  64  major ID
- illegal_o  out  1  present only with DECODE_ILLEGAL_TRAP_EN

## Operation
- Format mask bit weights come from the package: A=2**0, B=2**1, D=2**2, DQ=2**3, DS=2**4, DX=2**5, I=2**6, M=2**7, MD=2**8, MDS=2**9, SC=2**10, VA=2**11, VC=2**12, VX=2**13, X=2**14, XFL=2**15, XFX=2**16, XL=2**17, XO=2**18, XS=2**19, XX2=2**20, XX3=2**21, XX4=2**22, Z22=2**23, Z23=2**24, EVX=2**25.
- Primary opcode to mask:
  - 16 -> B; 18 -> I; 17 -> SC
  - 7–15, 24–29, 32–55 -> D
  - 20, 21, 23 -> M
  - 30 -> MD|MDS
  - 31 -> X|XO|XFX|XS
  - 19 -> XL|XFX
  - 58, 62 -> DS
  - 56, 61 -> DQ|DS
  - 4 -> VA|VC|VX
  - 59, 63 -> A|X|XFL|Z22|Z23
  - 60 -> XX2|XX3|XX4
  - all others -> 0 (illegal)
- Multiple bits may be set. Downstream decoders resolve the ambiguity by extended opcode.
- Accept occurs when fetchValid_i && fetchReady_o && !flush_i. On accept, the instruction takes the current ID counter value and the counter increments, wrapping 2**64-1 -> 0.
- Data path: output register plus skid register.
  - Accept with output register empty, or with output being consumed (!stall_i): load the output register.
  - Accept while stall_i is high and the output register is valid: load the skid register.
  - When stall_i is low and the skid register is valid: the skid register moves to output, and a same-cycle accept goes to skid.
- fetchReady_o = registered !(skid valid next cycle).
- flush_i: clear the output and skid valids; drop the same-cycle input; the ID counter holds. Flush has priority over accept and stall.
- Bundle fields hold while stall_i is high.

## Timing
- Reset: enable_o=0, fetchReady_o=1, ID counter=0, all data outputs 0, illegal_o=0.
- Latency: accept in cycle N -> enable_o in cycle N+1 (no stall).
- Throughput: 1 per cycle. Stall assertion costs no bubble; stall release drains the skid first.
- Reset mid-stream discards both entries. The first post-reset accepted instruction gets ID 0.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - Mask-zero instructions are forwarded with instFormat_o=0 and illegal_o=1.
  - They consume an ID.
- Not defined:
  - Mask-zero instructions are accepted (fetchReady_o honoured) and silently dropped.
  - No ID is consumed.
  - The illegal_o port does not exist.

## Structure
- Package decode_pkg holds:
  - format weight constants
  - unit IDs (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6)
  - width constants
  - the format mask typedef
- Sub-module decode_format_lut: combinational opcode -> 26-bit mask. The stage instantiates it once on the input side.

## Test plan
- Reset, then accept opcode 16 at address 0x100 -> next cycle enable_o=1, mask=2**1, instMajId_o=0, address 0x100.
- Back-to-back opcodes 18, 14, 31 -> masks 2**6, 2**2, X|XO|XFX|XS with IDs 0, 1, 2 on consecutive cycles.
- Raise stall_i for 3 cycles while fetch streams -> skid fills, fetchReady_o=0 one cycle later, no instruction lost or duplicated, IDs contiguous after release.
- Opcode 1 with DECODE_ILLEGAL_TRAP_EN -> illegal_o=1, mask 0, ID consumed. Without the macro -> no enable_o, next instruction keeps the ID.
- flush_i with both entries full plus a valid input -> enable_o=0 next cycle, fetchReady_o=1, counter unchanged.
- Preload the counter to 2**64-1 via the bench hook and accept two instructions -> IDs 2**64-1 then 0.
